cmos_frame_capture: RTL and testbench

- Front-end stage on the camera pixel clock. Directly upstream of the VRAM write port.
- Registers raw OV7670 sync and data pins and frames them on vsync/href. Pairs RGB565 bytes into RGB444 pixels.
- Emits a write strobe, a linear frame-buffer address and the pixel word, with per-line and per-frame status.
- Discards the first frames after reset while the sensor settles.

---
 rtl/cam_pkg.sv | 27 ++
 rtl/cmos_frame_capture_if.sv | 38 +++
 rtl/cmos_byte_pairer.sv | 42 ++++
 rtl/cmos_frame_capture.sv | 180 ++++++++++++++++++
 tb/tb_cmos_frame_capture.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
`default_nettype none
// ==========================================================================
// cam_pkg : shared geometry, capture state encoding and RGB565->RGB444 packing
// Rev 1.0
// ==========================================================================
package cam_pkg;

   localparam int H_ACTIVE     = 320;
   localparam int V_ACTIVE     = 240;
   localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
   localparam int PIXEL_WIDTH  = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      DISCARD = 2'd2,
      ACTIVE  = 2'd3
   } capture_state_t;

   // b0 = {R5, G6[5:3]}, b1 = {G6[2:0], B5}; keep the top 4 bits of each channel
   function automatic logic [PIXEL_WIDTH-1:0] rgb565_to_rgb444(input logic [7:0] b0,
                                                               input logic [7:0] b1);
      return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmos_frame_capture_if.sv
`default_nettype none
// ==========================================================================
// cmos_frame_capture_if : sensor pins in, frame-buffer write port and status out
// Rev 1.0
// ==========================================================================
interface cmos_frame_capture_if
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = cam_pkg::PIXEL_WIDTH,
   parameter int ADDR_WIDTH = $clog2(cam_pkg::FRAME_PIXELS)
);

   logic                  vsync_cmos_i;
   logic                  href_cmos_i;
   logic [7:0]            pixel_data_cmos_i;
   logic                  capture_en_i;
   logic                  wr_en_o;
   logic [ADDR_WIDTH-1:0] wr_addr_o;
   logic [DATA_WIDTH-1:0] wr_data_o;
   logic                  frame_start_o;
   logic                  frame_done_o;
   logic                  line_error_o;
   logic [7:0]            frame_count_o;

   modport master (
      output vsync_cmos_i, href_cmos_i, pixel_data_cmos_i, capture_en_i,
      input  wr_en_o, wr_addr_o, wr_data_o, frame_start_o, frame_done_o,
             line_error_o, frame_count_o
   );

   modport slave (
      input  vsync_cmos_i, href_cmos_i, pixel_data_cmos_i, capture_en_i,
      output wr_en_o, wr_addr_o, wr_data_o, frame_start_o, frame_done_o,
             line_error_o, frame_count_o
   );

endinterface
`default_nettype wire

// File: rtl/cmos_byte_pairer.sv
`default_nettype none
// ==========================================================================
// cmos_byte_pairer : alternates first/second byte while href is high and packs pixels
// Rev 1.0
// ==========================================================================
module cmos_byte_pairer
   import cam_pkg::*;
(
   input  logic                   pixel_clk_cmos_i,
   input  logic                   reset_i,
   input  logic                   href,
   input  logic                   href_prev,
   input  logic [7:0]             data,
   output logic                   pixel_valid,
   output logic [PIXEL_WIDTH-1:0] pixel,
   output logic                   odd_byte
);

   logic       r_second;
   logic [7:0] r_first;

   always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
      if (reset_i) begin
         r_second <= 1'b0;
         r_first  <= 8'd0;
      end else if (!href) begin
         r_second <= 1'b0;
      end else begin
         r_second <= ~r_second;
         if (!r_second) begin
            r_first <= data;
         end
      end
   end

   assign pixel_valid = href & r_second;
   assign pixel       = rgb565_to_rgb444(r_first, data);
   // A first byte still waiting for its partner when href drops means an odd count
   assign odd_byte    = ~href & href_prev & r_second;

endmodule
`default_nettype wire

// File: rtl/cmos_frame_capture.sv
`default_nettype none
// ==========================================================================
// cmos_frame_capture : OV7670 capture front-end, frames sensor bytes into RGB444 writes
// Rev 1.0
// ==========================================================================
module cmos_frame_capture
   import cam_pkg::*;
#(
   parameter int H_ACTIVE    = cam_pkg::H_ACTIVE,
   parameter int V_ACTIVE    = cam_pkg::V_ACTIVE,
   parameter int DATA_WIDTH  = cam_pkg::PIXEL_WIDTH,
   parameter int ADDR_WIDTH  = $clog2(cam_pkg::FRAME_PIXELS),
   parameter int SKIP_FRAMES = 2
) (
   input logic                 pixel_clk_cmos_i,
   input logic                 reset_i,
   cmos_frame_capture_if.slave cam
);

   localparam logic [1:0] c_st_idle    = IDLE;
   localparam logic [1:0] c_st_sync    = SYNC;
   localparam logic [1:0] c_st_discard = DISCARD;
   localparam logic [1:0] c_st_active  = ACTIVE;

   localparam int XW = $clog2(H_ACTIVE + 2);
   localparam int YW = $clog2(V_ACTIVE + 1);
   localparam logic [XW-1:0]         c_x_full    = XW'(H_ACTIVE);
   localparam logic [XW-1:0]         c_x_sat     = XW'(H_ACTIVE + 1);
   localparam logic [XW-1:0]         c_x_one     = XW'(1);
   localparam logic [YW-1:0]         c_y_full    = YW'(V_ACTIVE);
   localparam logic [YW-1:0]         c_y_one     = YW'(1);
   localparam logic [ADDR_WIDTH-1:0] c_line_step = ADDR_WIDTH'(H_ACTIVE);
   localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
   localparam logic [7:0]            c_skip_init = 8'(SKIP_FRAMES);

   logic                   r_vsync, r_vsync_d, r_href, r_href_d;
   logic [7:0]             r_data;
   logic [1:0]             r_state;
   logic [7:0]             r_skip;
   logic [XW-1:0]          r_x;
   logic [YW-1:0]          r_y;
   logic [ADDR_WIDTH-1:0]  r_line_base, r_addr;
   logic                   r_wr_en, r_frame_start, r_frame_done, r_line_error;
   logic [ADDR_WIDTH-1:0]  r_wr_addr;
   logic [DATA_WIDTH-1:0]  r_wr_data;
   logic [7:0]             r_frame_count;

   logic                   w_pixel_valid, w_odd_byte;
   logic [PIXEL_WIDTH-1:0] w_pixel;
   logic                   w_vsync_rise, w_vsync_fall, w_href_fall, w_abort, w_line_end;
   logic                   w_line_live, w_in_line;

   always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
      if (reset_i) begin
         r_vsync   <= 1'b0;
         r_vsync_d <= 1'b0;
         r_href    <= 1'b0;
         r_href_d  <= 1'b0;
         r_data    <= 8'd0;
      end else begin
         r_vsync   <= cam.vsync_cmos_i;
         r_vsync_d <= r_vsync;
         r_href    <= cam.href_cmos_i;
         r_href_d  <= r_href;
         r_data    <= cam.pixel_data_cmos_i;
      end
   end

   cmos_byte_pairer u_pairer (
      .pixel_clk_cmos_i (pixel_clk_cmos_i),
      .reset_i          (reset_i),
      .href             (r_href),
      .href_prev        (r_href_d),
      .data             (r_data),
      .pixel_valid      (w_pixel_valid),
      .pixel            (w_pixel),
      .odd_byte         (w_odd_byte)
   );

   assign w_vsync_rise = r_vsync & ~r_vsync_d;
   assign w_vsync_fall = ~r_vsync & r_vsync_d;
   assign w_href_fall  = ~r_href & r_href_d;
   assign w_abort      = w_vsync_rise & r_href;
   assign w_line_end   = w_href_fall | w_abort;
   assign w_line_live  = (r_y < c_y_full);
   assign w_in_line    = (r_x < c_x_full);

   always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
      if (reset_i) begin
         r_state       <= c_st_idle;
         r_skip        <= c_skip_init;
         r_x           <= '0;
         r_y           <= '0;
         r_line_base   <= '0;
         r_addr        <= '0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_line_error  <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         r_wr_en       <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_line_error  <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (r_vsync) begin
                  r_state <= c_st_sync;
               end
            end
            c_st_sync: begin
               if (w_vsync_fall) begin
                  if ((r_skip == 8'd0) && cam.capture_en_i) begin
                     r_state       <= c_st_active;
                     r_frame_start <= 1'b1;
                     r_line_base   <= '0;
                     r_addr        <= '0;
                     r_x           <= '0;
                     r_y           <= '0;
                  end else begin
                     r_state <= c_st_discard;
                     if (r_skip != 8'd0) begin
                        r_skip <= r_skip - 8'd1;
                     end
                  end
               end
            end
            c_st_discard: begin
               if (w_vsync_rise) begin
                  r_state <= c_st_sync;
               end
            end
            c_st_active: begin
               // A pixel completing in the abort cycle belongs to a dropped line
               if (w_pixel_valid && !w_vsync_rise) begin
                  if (w_line_live && w_in_line) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= DATA_WIDTH'(w_pixel);
                     r_addr    <= r_addr + c_addr_one;
                  end
                  if (r_x != c_x_sat) begin
                     r_x <= r_x + c_x_one;
                  end
               end
               if (w_line_end) begin
                  r_x <= '0;
                  if (w_line_live) begin
                     if (w_abort || w_odd_byte || (r_x != c_x_full)) begin
                        r_line_error <= 1'b1;
                     end
                     r_line_base <= r_line_base + c_line_step;
                     r_addr      <= r_line_base + c_line_step;
                     r_y         <= r_y + c_y_one;
                  end
               end
               if (w_vsync_rise) begin
                  r_frame_done  <= 1'b1;
                  r_frame_count <= r_frame_count + 8'd1;
                  r_state       <= c_st_sync;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign cam.wr_en_o       = r_wr_en;
   assign cam.wr_addr_o     = r_wr_addr;
   assign cam.wr_data_o     = r_wr_data;
   assign cam.frame_start_o = r_frame_start;
   assign cam.frame_done_o  = r_frame_done;
   assign cam.line_error_o  = r_line_error;
   assign cam.frame_count_o = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_cmos_frame_capture.sv
`default_nettype none
// ==========================================================================
// tb_cmos_frame_capture : directed frames against a bench-side write model
// Rev 1.0
// ==========================================================================
module tb_cmos_frame_capture;

   localparam int H    = 16;
   localparam int V    = 6;
   localparam int AW   = $clog2(H * V);
   localparam int DW   = 12;
   localparam int SKIP = 2;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmos_frame_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cam ();

   cmos_frame_capture #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .SKIP_FRAMES (SKIP)
   ) dut (
      .pixel_clk_cmos_i (clk),
      .reset_i          (rst),
      .cam              (cam)
   );

   wr_t        act_q[$];
   wr_t        exp_q[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         act_start = 0, act_done = 0, act_err = 0, exp_err = 0;
   int         line_y = 0;
   bit         exp_cap = 1'b0;
   logic [7:0] lb [0:63];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (cam.wr_en_o) act_q.push_back('{int'(cam.wr_addr_o), int'(cam.wr_data_o), cyc});
         if (cam.frame_start_o) act_start++;
         if (cam.frame_done_o) act_done++;
         if (cam.line_error_o) act_err++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int pack(input logic [7:0] b0, input logic [7:0] b1);
      logic [11:0] p;
      p = {b0[7:4], b0[2:0], b1[7], b1[4:1]};
      return int'(p);
   endfunction

   task automatic fill_line(input int seed);
      for (int i = 0; i < 64; i++) lb[i] = 8'((seed * 29 + i * 13 + 7) & 255);
   endtask

   task automatic send_line(input int n, input bit drop);
      for (int i = 0; i < n; i++) begin
         cam.href_cmos_i       = 1'b1;
         cam.pixel_data_cmos_i = lb[i];
         if ((i % 2 == 1) && exp_cap && (line_y < V) && (i / 2 < H))
            exp_q.push_back('{line_y * H + i / 2, pack(lb[i-1], lb[i]), cyc + 2});
         tick();
      end
      if (drop) begin
         cam.href_cmos_i       = 1'b0;
         cam.pixel_data_cmos_i = 8'd0;
         if (exp_cap && (line_y < V) && ((n % 2 == 1) || (n / 2 != H))) exp_err++;
         line_y++;
         tick(4);
      end
   endtask

   task automatic vsync_rise();
      cam.vsync_cmos_i = 1'b1;
      tick();
      cam.href_cmos_i       = 1'b0;
      cam.pixel_data_cmos_i = 8'd0;
      tick(5);
   endtask

   task automatic vsync_fall();
      cam.vsync_cmos_i = 1'b0;
      line_y = 0;
      tick(4);
   endtask

   task automatic clear_scoreboard();
      act_q.delete();
      exp_q.delete();
      act_start = 0;
      act_done  = 0;
      act_err   = 0;
      exp_err   = 0;
   endtask

   task automatic run_frame(input int seed, input bit cap);
      exp_cap = cap;
      vsync_fall();
      for (int y = 0; y < V; y++) begin
         fill_line(seed * 10 + y);
         send_line(2 * H, 1'b1);
      end
   endtask

   task automatic check_frame(input string tag, input int e_start, input int e_done, input int e_fc);
      chk({tag, "_nwr"}, act_q.size(), exp_q.size());
      for (int i = 0; (i < act_q.size()) && (i < exp_q.size()); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), act_q[i].addr, exp_q[i].addr);
         chk($sformatf("%s_data%0d", tag, i), act_q[i].data, exp_q[i].data);
         chk($sformatf("%s_cyc%0d", tag, i), act_q[i].cyc, exp_q[i].cyc);
      end
      chk({tag, "_start"}, act_start, e_start);
      chk({tag, "_done"}, act_done, e_done);
      chk({tag, "_lerr"}, act_err, exp_err);
      chk({tag, "_fcnt"}, cam.frame_count_o, e_fc);
      clear_scoreboard();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_wr_en"}, cam.wr_en_o, 0);
      chk({tag, "_wr_addr"}, cam.wr_addr_o, 0);
      chk({tag, "_wr_data"}, cam.wr_data_o, 0);
      chk({tag, "_start"}, cam.frame_start_o, 0);
      chk({tag, "_done"}, cam.frame_done_o, 0);
      chk({tag, "_lerr"}, cam.line_error_o, 0);
      chk({tag, "_fcnt"}, cam.frame_count_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cam.vsync_cmos_i      = 1'b0;
      cam.href_cmos_i       = 1'b0;
      cam.pixel_data_cmos_i = 8'd0;
      cam.capture_en_i      = 1'b1;
      rst = 1'b1;
      tick(3);
      chk_outputs_zero("reset");
      rst = 1'b0;
      tick(2);

      // Two settling frames are dropped, the third is captured
      vsync_rise();
      run_frame(1, 1'b0);
      vsync_rise();
      check_frame("f1", 0, 0, 0);
      run_frame(2, 1'b0);
      vsync_rise();
      check_frame("f2", 0, 0, 0);
      run_frame(3, 1'b1);
      vsync_rise();
      check_frame("f3", 1, 1, 1);

      // Known byte pair, odd-length line, over-long line, surplus line
      exp_cap = 1'b1;
      vsync_fall();
      fill_line(40);
      lb[0] = 8'hA5;
      lb[1] = 8'h3C;
      send_line(2 * H, 1'b1);
      fill_line(41);
      send_line(2 * H + 1, 1'b1);
      fill_line(42);
      send_line(2 * H, 1'b1);
      fill_line(43);
      send_line(2 * H + 4, 1'b1);
      for (int y = 4; y < V + 1; y++) begin
         fill_line(40 + y);
         send_line(2 * H, 1'b1);
      end
      vsync_rise();
      if (act_q.size() > 0) chk("pair_data", act_q[0].data, 32'hAAE);
      else chk("pair_data", 32'hFFFF_FFFF, 32'hAAE);
      check_frame("f4", 1, 1, 2);

      // Capture disabled at the vsync fall, enabled mid-frame
      cam.capture_en_i = 1'b0;
      exp_cap = 1'b0;
      vsync_fall();
      for (int y = 0; y < V; y++) begin
         fill_line(50 + y);
         if (y == 2) cam.capture_en_i = 1'b1;
         send_line(2 * H, 1'b1);
      end
      vsync_rise();
      check_frame("f5", 0, 0, 2);

      // Short frame whose last line is cut by vsync
      exp_cap = 1'b1;
      vsync_fall();
      for (int y = 0; y < 3; y++) begin
         fill_line(60 + y);
         send_line(2 * H, 1'b1);
      end
      fill_line(63);
      send_line(10, 1'b0);
      exp_err++;
      vsync_rise();
      check_frame("f6", 1, 1, 3);

      // Reset in the middle of a captured line
      exp_cap = 1'b1;
      vsync_fall();
      for (int y = 0; y < 2; y++) begin
         fill_line(70 + y);
         send_line(2 * H, 1'b1);
      end
      fill_line(72);
      send_line(6, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_outputs_zero("rst_mid");
      tick(2);
      cam.href_cmos_i       = 1'b0;
      cam.pixel_data_cmos_i = 8'd0;
      rst = 1'b0;
      clear_scoreboard();
      tick(2);

      vsync_rise();
      run_frame(8, 1'b0);
      vsync_rise();
      check_frame("r1", 0, 0, 0);
      run_frame(9, 1'b0);
      vsync_rise();
      check_frame("r2", 0, 0, 0);
      run_frame(10, 1'b1);
      vsync_rise();
      check_frame("r3", 1, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
